// File: rtl/traffic_pkg.sv
// Shared definitions for the country-road sensor and the signal controller.
// Holds the FSM encoding and the default timing constants.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_DEBOUNCE = 4;
    localparam int DEFAULT_HOLD_CYC = 3;

endpackage

// File: rtl/country_car_sensor_loop_debouncer.sv
// One inductive loop: 2-flop synchronizer, debounce counter and rising-edge detect.
// The level only follows the synchronized input after DEBOUNCE consecutive mismatches.
module loop_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          prev_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            level     <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= level;
            if (sync2_reg != level) begin
                if (cnt_reg == CW'(DEBOUNCE - 1)) begin
                    level   <= ~level;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // Single-cycle pulse on the debounced 0->1 transition only
    assign rise = level & ~prev_reg;

endmodule

// File: rtl/country_car_sensor.sv
// Car-present request for the country road: debounced arrival/departure loops feed a
// saturating queue counter, and a small FSM holds X high a few cycles after the queue empties.
module country_car_sensor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int CNT_W    = 4,
    parameter int HOLD_CYC = DEFAULT_HOLD_CYC
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             loop_in_raw,
    input  logic             loop_out_raw,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow,
    output logic             underflow
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [1:0] raw_bus;
    logic [1:0] rise_bus;
    logic [1:0] levels_unused;

    assign raw_bus = {loop_out_raw, loop_in_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_loop
            loop_debouncer #(
                .DEBOUNCE(DEBOUNCE)
            ) u_deb (
                .clock  (clock),
                .clear_n(clear_n),
                .raw    (raw_bus[gi]),
                .level  (levels_unused[gi]),
                .rise   (rise_bus[gi])
            );
        end
    endgenerate

    // Simultaneous arrival and departure cancel out, so neither flag is touched
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            car_count <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (rise_bus)
                2'b01: begin
                    if (car_count == {CNT_W{1'b1}}) overflow <= 1'b1;
                    else                            car_count <= car_count + CNT_W'(1);
                end
                2'b10: begin
                    if (car_count == '0) underflow <= 1'b1;
                    else                 car_count <= car_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    state_t        state_reg, state_next;
    logic [HW-1:0] hold_reg, hold_next;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            X         <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            X         <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                if (car_count != '0) state_next = REQ;
            end
            REQ: begin
                if (car_count == '0) begin
                    state_next = HOLD;
                    hold_next  = HW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (car_count != '0)    state_next = REQ;
                else if (hold_reg == '0) state_next = IDLE;
                else                    hold_next  = hold_reg - HW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
